jt49_env_step: RTL and testbench
================================

# jt49_env_step

Envelope step generator for the jt49 PSG core. Sits directly downstream of the envelope-period `jt49_div` instance: it consumes that divider's `div` square wave, advances a 5-bit envelope on every rising edge of it, and shapes the sequence according to the 4-bit envelope shape register (CONT/ATT/ALT/HOLD). Its `env` output feeds the channel amplitude/volume stage.

## Interface
Parameters:
- none.

Ports:
- clk      input   1  system clock.
- rst      input   1  reset; one clock, synchronous, active-high.
- cen      input   1  clock enable; state advances only on cycles with cen=1, except `restart`.
- step     input   1  `div` output of the upstream `jt49_div`; the block uses its rising edges.
- shape    input   4  {CONT, ATT, ALT, HOLD}; sampled only when `restart`=1.
- restart  input   1  single-cycle pulse on a write to the shape register; honoured regardless of `cen`.
- env      output  5  envelope level, 0..31.
- held     output  1  1 while the envelope is frozen.

## Operation
Registered state:
- `step_l`: previous `step`.
- `cnt[4:0]`: step counter.
- `dir`: 1 = attack (rising), 0 = decay.
- `hold`: envelope frozen.
- `shp_l[3:0]`: latched shape.

Reset (rst=1): step_l=0, cnt=0, dir=0, hold=1, shp_l=0, so env=0 and held=1.

Restart (restart=1, any cen):
- shp_l<=shape, cnt<=0, dir<=shape[ATT], hold<=0.
- step_l still updates on that cycle if cen=1.

Tick: cen=1 & step=1 & step_l=0 & restart=0.
- step_l<=step on every cen=1 cycle.

On a tick while hold=0:
- cnt<=cnt+1, wrapping mod 32.
- The end-of-cycle check applies only to the tick where cnt==31:
  - CONT=0: hold<=1, and the final level is 0. This covers shapes 0x0-0x7.
  - CONT=1, HOLD=1: hold<=1, and the final level is 31 when ATT^ALT=1, otherwise 0. This covers 0x9, 0xB, 0xD, 0xF.
  - CONT=1, HOLD=0, ALT=1: dir<=~dir, continue. This covers 0xA and 0xE.
  - CONT=1, HOLD=0, ALT=0: continue with the same dir. This covers 0x8 and 0xC.
- Ticks while hold=1 are ignored, and cnt does not change.

Output decode (combinational from registered state):
- hold=0: env = dir ? cnt : ~cnt.
- hold=1: env = (shp_l[CONT] & (shp_l[ATT]^shp_l[ALT])) ? 31 : 0.
- held = hold.

## Timing
- A rising edge of `step` is detected on the first cen=1 clock where step=1 and step_l=0. cnt, dir and hold update on that same clock edge, and env/held reflect them immediately after it, with no additional pipeline stage.
- One env step is issued per `step` period, so a full ramp takes 32 `step` periods.
- Restart takes effect on the clock edge it is sampled:
  - Next env = 31 if shape[ATT]=0, else 0.
  - Next held = 0.
- Simultaneous events:
  - Restart with a tick: restart wins and the tick is discarded.
  - rst with anything: rst wins.
- Restart mid-ramp or mid-hold fully reinitialises cnt/dir/hold. No residue of the previous shape remains.
- `step` held high, or any number of cen=0 cycles, generates no extra ticks.
- A change on `shape` without `restart` has no effect.

## Test plan
- Reset, then 40 step periods with no restart -> env=0 and held=1 throughout.
- restart with shape=0x0 -> env=31 immediately. It then decrements once per step rising edge down to 0. On the 32nd tick held=1 and env=0, and further ticks leave env=0.
- shape=0xD -> env ramps 0..31. After the 32nd tick held=1 and env=31. After 40 more ticks it is still 31.
- shape=0xE -> env ramps 0..31, then 31..0, then 0..31. Direction flips exactly at each 32-tick boundary, and held stays 0.
- shape=0x8 with cen toggling every other cycle and `step` from `jt49_div` with period=3 -> env runs 31..0 repeatedly. Exactly one decrement occurs per div rising edge, with no double counts.
- Mid-ramp (env=17, shape 0xC) assert restart with shape=0xB on the same cycle as a step edge -> the tick is discarded and the next env=31. It then decays to 0 and holds at 31 (held=1).

Source files
------------

// File: rtl/jt49_env_step.sv
// Envelope step generator: advances a 5-bit level on each rising edge of the
// envelope divider output and shapes it with the CONT/ATT/ALT/HOLD register.
module jt49_env_step (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       step,
    input  logic [3:0] shape,
    input  logic       restart,
    output logic [4:0] env,
    output logic       held
);

    localparam int CONT = 3;
    localparam int ATT  = 2;
    localparam int ALT  = 1;
    localparam int HOLD = 0;

    logic       r_step_l;
    logic [4:0] r_cnt;
    logic       r_dir;
    logic       r_hold;
    logic [3:0] r_shp_l;

    logic       w_tick;
    logic       w_last;
    logic       w_hold_hi;

    assign w_tick    = cen & step & ~r_step_l & ~restart;
    assign w_last    = (r_cnt == 5'd31);
    assign w_hold_hi = r_shp_l[CONT] & (r_shp_l[ATT] ^ r_shp_l[ALT]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_l <= 1'b0;
            r_cnt    <= 5'd0;
            r_dir    <= 1'b0;
            r_hold   <= 1'b1;
            r_shp_l  <= 4'd0;
        end else begin
            if (cen)
                r_step_l <= step;
            // Restart outranks a coincident tick, which is simply dropped.
            if (restart) begin
                r_shp_l <= shape;
                r_cnt   <= 5'd0;
                r_dir   <= shape[ATT];
                r_hold  <= 1'b0;
            end else if (w_tick && !r_hold) begin
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    if (!r_shp_l[CONT] || r_shp_l[HOLD])
                        r_hold <= 1'b1;
                    else if (r_shp_l[ALT])
                        r_dir <= ~r_dir;
                end
            end
        end
    end

    // NOTE: env is assigned a default first so no path can infer a latch.
    always_comb begin
        env = 5'd0;
        if (r_hold)
            env = w_hold_hi ? 5'd31 : 5'd0;
        else
            env = r_dir ? r_cnt : ~r_cnt;
    end

    assign held = r_hold;

endmodule

// File: tb/tb_jt49_env_step.sv
// Directed self-checking bench for jt49_env_step: every expected level below
// follows from the shape definitions and the number of step edges issued.
module tb_jt49_env_step;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       step = 1'b0;
    logic [3:0] shape = 4'd0;
    logic       restart = 1'b0;
    logic [4:0] env;
    logic       held;

    int n_cmp = 0;
    int n_bad = 0;

    jt49_env_step dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .step    (step),
        .shape   (shape),
        .restart (restart),
        .env     (env),
        .held    (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        cen  = 1'b1;
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
    endtask

    task automatic do_restart(input logic [3:0] s, input logic c);
        cen     = c;
        shape   = s;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        cen     = 1'b1;
    endtask

    initial begin
        int ticks;
        logic div;
        logic last_seen;
        int dcnt;
        logic [4:0] e;

        // Reset state, then free-running steps without restart.
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_env", env, 5'd0);
        check("reset_held", {4'd0, held}, 5'd1);
        for (int i = 0; i < 40; i++) begin
            do_tick();
            check("idle_env", env, 5'd0);
            check("idle_held", {4'd0, held}, 5'd1);
        end

        // Shape 0x0: decay 31..0, then hold at 0.
        do_restart(4'h0, 1'b1);
        check("s0_start_env", env, 5'd31);
        check("s0_start_held", {4'd0, held}, 5'd0);
        for (int i = 1; i <= 31; i++) begin
            do_tick();
            e = 5'(31 - i);
            check("s0_ramp", env, e);
        end
        check("s0_31_held", {4'd0, held}, 5'd0);
        // A step edge while cen=0 must not tick.
        cen  = 1'b0;
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        check("s0_cen0_held", {4'd0, held}, 5'd0);
        do_tick();
        check("s0_end_env", env, 5'd0);
        check("s0_end_held", {4'd0, held}, 5'd1);
        for (int i = 0; i < 5; i++) begin
            do_tick();
            check("s0_after_env", env, 5'd0);
        end

        // Shape 0xD: attack 0..31, then hold at 31.
        do_restart(4'hD, 1'b1);
        check("sD_start_env", env, 5'd0);
        for (int i = 1; i <= 31; i++) begin
            do_tick();
            e = 5'(i);
            check("sD_ramp", env, e);
        end
        do_tick();
        check("sD_end_env", env, 5'd31);
        check("sD_end_held", {4'd0, held}, 5'd1);
        shape = 4'h0;
        for (int i = 0; i < 40; i++)
            do_tick();
        check("sD_after_env", env, 5'd31);
        check("sD_after_held", {4'd0, held}, 5'd1);

        // Shape 0xE: triangle, direction flips every 32 ticks, never holds.
        do_restart(4'hE, 1'b1);
        check("sE_start_env", env, 5'd0);
        for (int t = 1; t <= 96; t++) begin
            do_tick();
            e = ((t / 32) % 2 == 0) ? 5'(t % 32) : 5'(31 - (t % 32));
            check("sE_tri", env, e);
            check("sE_held", {4'd0, held}, 5'd0);
        end

        // Shape 0x8 with cen on alternate clocks and a period-3 divider as step.
        do_restart(4'h8, 1'b0);
        check("s8_start_env", env, 5'd31);
        div       = 1'b0;
        last_seen = 1'b0;
        dcnt      = 0;
        ticks     = 0;
        for (int p = 0; p < 240; p++) begin
            cen  = 1'b1;
            step = div;
            cycle();
            if (div && !last_seen)
                ticks++;
            last_seen = div;
            cen = 1'b0;
            cycle();
            e = 5'(31 - (ticks % 32));
            check("s8_saw", env, e);
            dcnt++;
            if (dcnt == 3) begin
                dcnt = 0;
                div  = ~div;
            end
        end
        check("s8_held", {4'd0, held}, 5'd0);
        step = 1'b0;
        cen  = 1'b1;
        cycle();

        // Shape 0xC to level 17, then restart 0xB on the same clock as a step edge.
        do_restart(4'hC, 1'b1);
        for (int i = 0; i < 17; i++)
            do_tick();
        check("sC_mid_env", env, 5'd17);
        cen     = 1'b1;
        step    = 1'b1;
        shape   = 4'hB;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        step    = 1'b0;
        check("sB_restart_env", env, 5'd31);
        check("sB_restart_held", {4'd0, held}, 5'd0);
        cycle();
        for (int i = 1; i <= 31; i++) begin
            do_tick();
            e = 5'(31 - i);
            check("sB_ramp", env, e);
        end
        do_tick();
        check("sB_end_env", env, 5'd31);
        check("sB_end_held", {4'd0, held}, 5'd1);

        // Reset wins over a coincident restart.
        rst     = 1'b1;
        restart = 1'b1;
        shape   = 4'h0;
        cycle();
        rst     = 1'b0;
        restart = 1'b0;
        check("rst_win_env", env, 5'd0);
        check("rst_win_held", {4'd0, held}, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
